merger_readout_ctrl: RTL and testbench

- Per-event readout sequencer placed downstream of a 4-input, 2-layer merger tree.
- Opens an event window on `start` and drives the merger's read strobe.
- Honours downstream back-pressure and enforces a fixed per-event cycle budget.
- On budget expiry: flushes residual merger contents, then reports per-input word counts and a truncation flag.

---
 rtl/merger_readout_ctrl.sv | 155 +++++++++++++++
 tb/tb_merger_readout_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merger_readout_ctrl.sv
// Per-event readout sequencer behind a 4-input merger tree: RUN window, flush, per-input counts.
// Optional key-order checker is built when MERGER_READOUT_ORDER_CHECK_EN is defined.
module merger_readout_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ACTIVE_MSB = 11,
  parameter int ACTIVE_LSB = 6,
  parameter int MAX_CYCLES = 100,
  parameter int DRAIN_IDLE = 4,
  parameter int CNT_WIDTH  = 7
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_en,
  input  logic                      i_start,
  input  logic [DATA_WIDTH-1:0]     i_merge_data,
  input  logic [1:0]                i_merge_index,
  input  logic                      i_merge_valid,
  output logic                      o_merge_read,
  input  logic                      i_out_full,
  output logic [DATA_WIDTH-1:0]     o_out_data,
  output logic [1:0]                o_out_index,
  output logic                      o_out_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_truncated,
  output logic                      o_missed_start,
  output logic [4*CNT_WIDTH-1:0]    o_cnt_bus,
  output logic                      o_order_err
);

  localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CYC  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [IDLE_W-1:0]    LAST_IDLE = IDLE_W'(DRAIN_IDLE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  if (MAX_CYCLES < 2 || MAX_CYCLES > 2**CNT_WIDTH || DRAIN_IDLE < 3 ||
      ACTIVE_MSB >= DATA_WIDTH || ACTIVE_LSB > ACTIVE_MSB) begin : g_param_chk
    $error("merger_readout_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]            r_cyc_cnt;
  logic [IDLE_W-1:0]               r_idle_cnt;
  logic [3:0][CNT_WIDTH-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0]           r_out_data;
  logic [1:0]                      r_out_index;
  logic                            r_out_valid, r_truncated, r_missed_start;
  logic                            w_merge_read, w_start_ok, w_begin, w_fwd, w_discard;

  always_comb begin
    w_state_nxt  = r_state;
    w_merge_read = 1'b0;
    w_begin      = 1'b0;
    w_start_ok   = i_en & i_start;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = S_RUN;
          w_begin     = 1'b1;
        end
      end
      S_RUN: begin
        w_merge_read = i_en & ~i_out_full;
        if (r_cyc_cnt == LAST_CYC) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // Drain ignores back-pressure: residual words are dropped, never forwarded.
        w_merge_read = i_en;
        if (!i_merge_valid && r_idle_cnt == LAST_IDLE) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_begin     = w_start_ok;
        w_state_nxt = w_start_ok ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fwd     = (r_state == S_RUN) & w_merge_read & i_merge_valid;
  assign w_discard = (r_state == S_FLUSH) & i_en & i_merge_valid;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_cyc_cnt      <= '0;
      r_idle_cnt     <= '0;
      r_cnt          <= '0;
      r_out_data     <= '0;
      r_out_index    <= '0;
      r_out_valid    <= 1'b0;
      r_truncated    <= 1'b0;
      r_missed_start <= 1'b0;
    end else if (i_en) begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_fwd;
      if (w_fwd) begin
        r_out_data  <= i_merge_data;
        r_out_index <= i_merge_index;
      end
      r_cyc_cnt  <= (r_state == S_RUN) ? r_cyc_cnt + 1'b1 : '0;
      r_idle_cnt <= (r_state == S_FLUSH && !i_merge_valid) ? r_idle_cnt + 1'b1 : '0;
      if (w_begin) begin
        r_cnt       <= '0;
        r_truncated <= 1'b0;
      end else begin
        if (w_fwd && r_cnt[i_merge_index] != CNT_MAX)
          r_cnt[i_merge_index] <= r_cnt[i_merge_index] + 1'b1;
        if (w_discard) r_truncated <= 1'b1;
      end
      if (w_start_ok && (r_state == S_RUN || r_state == S_FLUSH)) r_missed_start <= 1'b1;
    end
  end

`ifdef MERGER_READOUT_ORDER_CHECK_EN
  localparam int KEY_W = ACTIVE_MSB - ACTIVE_LSB + 1;
  logic [KEY_W-1:0] r_key;
  logic             r_key_vld, r_order_err;
  logic [KEY_W-1:0] w_key;

  assign w_key = i_merge_data[ACTIVE_MSB:ACTIVE_LSB];

  // First forwarded word of an event only seeds the reference key.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_key       <= '0;
      r_key_vld   <= 1'b0;
      r_order_err <= 1'b0;
    end else if (i_en) begin
      if (w_begin) begin
        r_key_vld <= 1'b0;
      end else if (w_fwd) begin
        r_key     <= w_key;
        r_key_vld <= 1'b1;
        if (r_key_vld && w_key < r_key) r_order_err <= 1'b1;
      end
    end
  end
  assign o_order_err = r_order_err;
`else
  assign o_order_err = 1'b0;
`endif

  assign o_merge_read   = w_merge_read;
  assign o_out_data     = r_out_data;
  assign o_out_index    = r_out_index;
  assign o_out_valid    = r_out_valid & i_en;
  assign o_busy         = (r_state == S_RUN) | (r_state == S_FLUSH);
  assign o_done         = (r_state == S_DONE) & i_en;
  assign o_truncated    = r_truncated;
  assign o_missed_start = r_missed_start;
  assign o_cnt_bus      = r_cnt;

endmodule

// File: tb/tb_merger_readout_ctrl.sv
// Randomised and directed bench for merger_readout_ctrl against an event-level reference model.
// Define MERGER_READOUT_ORDER_CHECK_EN for both files to exercise the order checker.
module tb_merger_readout_ctrl;
  localparam int MAXC  = 100;
  localparam int DRAIN = 4;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_FLUSH = 2, PH_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n, en, start, mv, full;
  logic [11:0] md;
  logic [1:0]  mi;
  logic        o_merge_read, o_out_valid, o_busy, o_done, o_truncated, o_missed_start, o_order_err;
  logic [11:0] o_out_data;
  logic [1:0]  o_out_index;
  logic [27:0] o_cnt_bus;

  merger_readout_ctrl dut (
    .i_clk(clk), .i_reset(rst_n), .i_en(en), .i_start(start),
    .i_merge_data(md), .i_merge_index(mi), .i_merge_valid(mv),
    .o_merge_read(o_merge_read), .i_out_full(full),
    .o_out_data(o_out_data), .o_out_index(o_out_index), .o_out_valid(o_out_valid),
    .o_busy(o_busy), .o_done(o_done), .o_truncated(o_truncated),
    .o_missed_start(o_missed_start), .o_cnt_bus(o_cnt_bus), .o_order_err(o_order_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: event phase, remaining RUN budget, quiet-cycle run length.
  int          m_phase, m_run_left, m_quiet;
  int          m_cnt[4];
  bit          m_trunc, m_missed, m_ov, m_err, m_have_key;
  logic [11:0] m_od;
  logic [1:0]  m_oi;
  logic [5:0]  m_key;

  logic [13:0] q[$];
  bit          auto_fill = 1'b0;
  int          cyc = 0, done_cyc = -1, start_cyc = 0, n_obs = 0, n_disc = 0;

  task automatic model_reset();
    m_phase = PH_IDLE; m_run_left = 0; m_quiet = 0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_trunc = 0; m_missed = 0; m_ov = 0; m_err = 0; m_have_key = 0;
    m_od = '0; m_oi = '0; m_key = '0;
  endtask

  task automatic begin_event();
    m_phase = PH_RUN; m_run_left = MAXC;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_trunc = 0; m_have_key = 0;
  endtask

  function automatic bit exp_read();
    return en && ((m_phase == PH_RUN && !full) || m_phase == PH_FLUSH);
  endfunction

  task automatic model_advance(output bit pop);
    bit rd;
    rd  = exp_read();
    pop = rd && mv;
    if (en) begin
      case (m_phase)
        PH_IDLE: begin
          m_ov = 0;
          if (start) begin_event();
        end
        PH_RUN: begin
          if (start) m_missed = 1;
          m_ov = rd && mv;
          if (m_ov) begin
            m_od = md; m_oi = mi;
            if (m_cnt[mi] < 127) m_cnt[mi]++;
            if (m_have_key && md[11:6] < m_key) m_err = 1;
            m_key = md[11:6]; m_have_key = 1;
          end
          m_run_left--;
          if (m_run_left == 0) begin m_phase = PH_FLUSH; m_quiet = 0; end
        end
        PH_FLUSH: begin
          if (start) m_missed = 1;
          m_ov = 0;
          if (mv) begin m_trunc = 1; m_quiet = 0; n_disc++; end
          else m_quiet++;
          if (m_quiet == DRAIN) m_phase = PH_DONE;
        end
        default: begin
          m_ov = 0;
          if (start) begin_event();
          else m_phase = PH_IDLE;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [27:0] exp_cnt;
    for (int k = 0; k < 4; k++) exp_cnt[k*7 +: 7] = 7'(m_cnt[k]);
    chk("merge_read", 32'(o_merge_read), 32'(exp_read()));
    chk("out_valid", 32'(o_out_valid), 32'(en && m_ov));
    if (en && m_ov) begin
      chk("out_data", 32'(o_out_data), 32'(m_od));
      chk("out_index", 32'(o_out_index), 32'(m_oi));
    end
    chk("busy", 32'(o_busy), 32'(m_phase == PH_RUN || m_phase == PH_FLUSH));
    chk("done", 32'(o_done), 32'(en && m_phase == PH_DONE));
    chk("truncated", 32'(o_truncated), 32'(m_trunc));
    chk("missed_start", 32'(o_missed_start), 32'(m_missed));
    chk("cnt_bus", 32'(o_cnt_bus), 32'(exp_cnt));
`ifdef MERGER_READOUT_ORDER_CHECK_EN
    chk("order_err", 32'(o_order_err), 32'(m_err));
`else
    chk("order_err", 32'(o_order_err), 32'd0);
`endif
    if (o_out_valid === 1'b1) n_obs++;
    if (o_done === 1'b1) done_cyc = cyc;
  endtask

  task automatic push_word(input logic [1:0] idx, input logic [5:0] key);
    q.push_back({idx, key, 6'($urandom)});
  endtask

  task automatic tick(input bit st, input int p_en, input int p_full);
    bit pop;
    if (auto_fill && q.size() < 3 && $urandom_range(1) == 1) q.push_back(14'($urandom));
    @(negedge clk);
    start = st;
    en    = ($urandom_range(99) < p_en);
    full  = ($urandom_range(99) < p_full);
    mv    = (q.size() > 0);
    if (mv) {mi, md} = q[0];
    else {mi, md} = 14'($urandom);
    #1 check_outputs();
    @(posedge clk);
    model_advance(pop);
    if (pop) void'(q.pop_front());
    cyc++;
  endtask

  task automatic run(input int n, input int p_en, input int p_full, input int p_start);
    repeat (n) tick($urandom_range(99) < p_start, p_en, p_full);
  endtask

  task automatic start_event();
    n_obs = 0; n_disc = 0; done_cyc = -1; start_cyc = cyc;
    tick(1'b1, 100, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_merge_read", 32'(o_merge_read), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_data", 32'(o_out_data), 32'd0);
    chk("rst_out_index", 32'(o_out_index), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_truncated", 32'(o_truncated), 32'd0);
    chk("rst_missed", 32'(o_missed_start), 32'd0);
    chk("rst_cnt_bus", 32'(o_cnt_bus), 32'd0);
    chk("rst_order_err", 32'(o_order_err), 32'd0);
    model_reset();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; mv = 1'b0; md = '0; mi = '0; full = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 100, 0);
    chk("init_cnt_bus", 32'(o_cnt_bus), 32'd0);

    // Basic event: five words, idle budget, drain
    push_word(2'd0, 6'd1); push_word(2'd1, 6'd2); push_word(2'd1, 6'd3);
    push_word(2'd3, 6'd4); push_word(2'd2, 6'd5);
    start_event();
    run(110, 100, 0, 0);
    chk("basic_cnt", 32'(o_cnt_bus), 32'({7'd1, 7'd1, 7'd2, 7'd1}));
    chk("basic_fwd", 32'(n_obs), 32'd5);
    chk("basic_trunc", 32'(o_truncated), 32'd0);
    chk("basic_done_lat", 32'(done_cyc - start_cyc), 32'(1 + MAXC + DRAIN));

    // Back-pressure over RUN cycles 10..19
    start_event();
    run(8, 100, 0, 0);
    push_word(2'd0, 6'd1); push_word(2'd0, 6'd2); push_word(2'd1, 6'd3); push_word(2'd2, 6'd4);
    push_word(2'd3, 6'd5); push_word(2'd3, 6'd6); push_word(2'd3, 6'd7); push_word(2'd1, 6'd8);
    run(2, 100, 0, 0);
    run(10, 100, 100, 0);
    run(90, 100, 0, 0);
    chk("bp_fwd", 32'(n_obs), 32'd8);
    chk("bp_cnt", 32'(o_cnt_bus), 32'({7'd3, 7'd1, 7'd2, 7'd2}));
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Truncation: valid through all of RUN plus three words into FLUSH
    for (int k = 0; k < MAXC + 3; k++) push_word(2'd2, 6'(k / 2));
    start_event();
    run(112, 100, 0, 0);
    chk("trunc_fwd", 32'(n_obs), 32'(MAXC));
    chk("trunc_disc", 32'(n_disc), 32'd3);
    chk("trunc_flag", 32'(o_truncated), 32'd1);
    chk("trunc_cnt", 32'(o_cnt_bus), 32'({7'd0, 7'(MAXC), 7'd0, 7'd0}));
    chk("trunc_drain_gap", 32'(done_cyc - (start_cyc + 1 + MAXC + 2)), 32'(DRAIN + 1));

    // Start during RUN is ignored; start on DONE reopens immediately
    push_word(2'd1, 6'd9); push_word(2'd3, 6'd9);
    start_event();
    run(20, 100, 0, 0);
    tick(1'b1, 100, 0);
    #1 chk("missed_start", 32'(o_missed_start), 32'd1);
    run(83, 100, 0, 0);
    tick(1'b1, 100, 0);
    chk("missed_done_lat", 32'(done_cyc - start_cyc), 32'(1 + MAXC + DRAIN));
    #1;
    chk("restart_busy", 32'(o_busy), 32'd1);
    chk("restart_cnt", 32'(o_cnt_bus), 32'd0);
    start_cyc = cyc - 1; done_cyc = -1;
    run(110, 100, 0, 0);
    chk("restart_done_lat", 32'(done_cyc - start_cyc), 32'(1 + MAXC + DRAIN));

    // Freeze for 7 cycles mid-RUN, with a word registered just before it
    start_event();
    run(30, 100, 0, 0);
    push_word(2'd0, 6'd3);
    run(1, 100, 0, 0);
    run(7, 0, 0, 50);
    run(80, 100, 0, 0);
    chk("freeze_done_lat", 32'(done_cyc - start_cyc), 32'(1 + MAXC + DRAIN + 7));
    chk("freeze_fwd", 32'(n_obs), 32'd1);

    // Asynchronous reset in the middle of FLUSH
    for (int k = 0; k < MAXC + 6; k++) push_word(2'(k), 6'd0);
    start_event();
    run(10, 100, 0, 0);
    tick(1'b1, 100, 0);
    run(MAXC - 8, 100, 0, 0);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    apply_reset();
    tick(1'b0, 100, 0);

    // Order checker: 3,5,4 within one event
    push_word(2'd0, 6'd3); push_word(2'd1, 6'd5); push_word(2'd2, 6'd4);
    start_event();
    run(3, 100, 0, 0);
    #1;
`ifdef MERGER_READOUT_ORDER_CHECK_EN
    chk("order_345", 32'(o_order_err), 32'd1);
`else
    chk("order_345", 32'(o_order_err), 32'd0);
`endif
    run(110, 100, 0, 0);

    // Falling key across an event boundary is legal
    apply_reset();
    push_word(2'd0, 6'd3); push_word(2'd1, 6'd5);
    start_event();
    run(110, 100, 0, 0);
    push_word(2'd2, 6'd1);
    start_event();
    run(110, 100, 0, 0);
    chk("order_cross_evt", 32'(o_order_err), 32'd0);
    chk("order_cross_cnt", 32'(o_cnt_bus), 32'({7'd0, 7'd1, 7'd0, 7'd0}));

    // Random traffic, enables, back-pressure and stray starts
    apply_reset();
    auto_fill = 1'b1;
    for (int e = 0; e < 6; e++) begin
      start_event();
      run(130, 90, 30, 3);
    end
    auto_fill = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
